prom_reader: RTL and testbench

PROM_READER -- requirements
Module: prom_reader

---
 rtl/prom_reader.sv | 158 +++++++++++++++
 tb/tb_prom_reader.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/prom_reader.sv
// Sequential PROM burst reader: holds each address WAIT_CYCLES+1 clocks, captures the word and
// hands it out through a VALID/READY register. Optional running checksum under PROM_READER_CHECKSUM_EN.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// S_IDLE   | waiting for START; PROM disabled, address holds
// S_ACCESS | PROM enabled, address stable, wait counter running down
// S_OUT    | captured word presented, waiting for READY
// S_FIN    | one-cycle completion, DONE asserted
module prom_reader #(
    parameter int ADDR_WIDTH  = 5,
    parameter int DATA_WIDTH  = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] start_a_i,
    input  logic [ADDR_WIDTH:0]   count_i,
    output logic                  busy_o,
    output logic [DATA_WIDTH-1:0] dout_o,
    output logic [ADDR_WIDTH-1:0] dout_a_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic                  done_o,
    output logic                  prom_e_o,
    output logic [ADDR_WIDTH-1:0] prom_a_o,
    input  logic [DATA_WIDTH-1:0] prom_q_i
`ifdef PROM_READER_CHECKSUM_EN
    ,
    output logic [DATA_WIDTH-1:0] checksum_o
`endif
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_OUT    = 2'd2,
        S_FIN    = 2'd3
    } state_t;

    localparam logic [3:0]          WAIT_LOAD = 4'(WAIT_CYCLES);
    localparam logic [ADDR_WIDTH:0] REM_ONE   = (ADDR_WIDTH+1)'(1);

    state_t                  state_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [ADDR_WIDTH-1:0]   addr_d;
    logic [ADDR_WIDTH:0]     rem_q;
    logic [ADDR_WIDTH:0]     rem_d;
    logic [3:0]              wait_q;
    logic                    busy_q;
    logic                    valid_q;
    logic                    done_q;
    logic                    prom_e_q;
    logic [DATA_WIDTH-1:0]   dout_q;
    logic [ADDR_WIDTH-1:0]   dout_a_q;
    logic                    handshake;

    // Address increment wraps naturally at the register width.
    assign addr_d    = addr_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    assign rem_d     = rem_q - REM_ONE;
    assign handshake = valid_q & ready_i;

`ifdef PROM_READER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] csum_q;
    logic [DATA_WIDTH-1:0] csum_d;

    assign csum_d     = csum_q + dout_q;
    assign checksum_o = csum_q;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            rem_q    <= '0;
            wait_q   <= '0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
            prom_e_q <= 1'b1;
            dout_q   <= '0;
            dout_a_q <= '0;
`ifdef PROM_READER_CHECKSUM_EN
            csum_q   <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        busy_q <= 1'b1;
`ifdef PROM_READER_CHECKSUM_EN
                        csum_q <= '0;
`endif
                        if (count_i != '0) begin
                            state_q  <= S_ACCESS;
                            addr_q   <= start_a_i;
                            rem_q    <= count_i;
                            wait_q   <= WAIT_LOAD;
                            prom_e_q <= 1'b0;
                        end else begin
                            // Empty transfer: straight to completion, PROM untouched.
                            state_q <= S_FIN;
                            done_q  <= 1'b1;
                        end
                    end
                end
                S_ACCESS: begin
                    if (wait_q == '0) begin
                        dout_q   <= prom_q_i;
                        dout_a_q <= addr_q;
                        valid_q  <= 1'b1;
                        prom_e_q <= 1'b1;
                        state_q  <= S_OUT;
                    end else begin
                        wait_q <= wait_q - 4'd1;
                    end
                end
                S_OUT: begin
                    if (handshake) begin
                        valid_q <= 1'b0;
                        rem_q   <= rem_d;
`ifdef PROM_READER_CHECKSUM_EN
                        csum_q  <= csum_d;
`endif
                        if (rem_q > REM_ONE) begin
                            addr_q   <= addr_d;
                            wait_q   <= WAIT_LOAD;
                            prom_e_q <= 1'b0;
                            state_q  <= S_ACCESS;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= S_FIN;
                        end
                    end
                end
                S_FIN: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy_o   = busy_q;
    assign valid_o  = valid_q;
    assign done_o   = done_q;
    assign dout_o   = dout_q;
    assign dout_a_o = dout_a_q;
    assign prom_e_o = prom_e_q;
    assign prom_a_o = addr_q;

endmodule

// File: tb/tb_prom_reader.sv
// Self-checking bench for prom_reader: PROM model Q = A ^ 0xA5, scoreboard of expected words.
// Checksum checks are compiled in when PROM_READER_CHECKSUM_EN is defined.
module tb_prom_reader;

    localparam int AW = 5;
    localparam int DW = 8;
    localparam int WC = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] start_a;
    logic [AW:0]   count;
    logic          busy;
    logic [DW-1:0] dout;
    logic [AW-1:0] dout_a;
    logic          valid;
    logic          ready;
    logic          done;
    logic          prom_e;
    logic [AW-1:0] prom_a;
    logic [DW-1:0] prom_q;
`ifdef PROM_READER_CHECKSUM_EN
    logic [DW-1:0] checksum;
`endif

    int checks   = 0;
    int failures = 0;

    logic [AW-1:0] exp_a[$];
    logic [DW-1:0] exp_d[$];
    logic [DW-1:0] exp_csum;

    always #5 clk = ~clk;

    assign prom_q = {{(DW-AW){1'b0}}, prom_a} ^ 8'hA5;

    prom_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_CYCLES(WC)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .start_i   (start),
        .start_a_i (start_a),
        .count_i   (count),
        .busy_o    (busy),
        .dout_o    (dout),
        .dout_a_o  (dout_a),
        .valid_o   (valid),
        .ready_i   (ready),
        .done_o    (done),
        .prom_e_o  (prom_e),
        .prom_a_o  (prom_a),
        .prom_q_i  (prom_q)
`ifdef PROM_READER_CHECKSUM_EN
        ,
        .checksum_o(checksum)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy"},   busy,   0);
        chk({tag, "_valid"},  valid,  0);
        chk({tag, "_done"},   done,   0);
        chk({tag, "_prom_e"}, prom_e, 1);
        chk({tag, "_prom_a"}, prom_a, 0);
        chk({tag, "_dout"},   dout,   0);
        chk({tag, "_dout_a"}, dout_a, 0);
`ifdef PROM_READER_CHECKSUM_EN
        chk({tag, "_csum"},   checksum, 0);
`endif
    endtask

    task automatic push_exp(input logic [AW-1:0] sa, input logic [AW:0] cnt);
        logic [AW-1:0] a;
        exp_csum = '0;
        for (int i = 0; i < int'(cnt); i++) begin
            a = sa + AW'(i);
            exp_a.push_back(a);
            exp_d.push_back({{(DW-AW){1'b0}}, a} ^ 8'hA5);
            exp_csum = exp_csum + ({{(DW-AW){1'b0}}, a} ^ 8'hA5);
        end
    endtask

    // Runs one transfer; stall = READY-low cycles per word, noise = keep START asserted while busy.
    task automatic do_xfer(input string tag, input logic [AW-1:0] sa, input logic [AW:0] cnt,
                           input int stall, input bit noise);
        int  lowrun     = 0;
        int  stall_left = 0;
        bit  prev_valid = 1'b0;
        bit  fin        = 1'b0;
        push_exp(sa, cnt);
        start   = 1'b1;
        start_a = sa;
        count   = cnt;
        ready   = 1'b1;
        step();
        chk({tag, "_busy_start"}, busy, 1);
        start   = noise;
        start_a = sa ^ 5'h11;
        count   = 6'd3;
        for (int cyc = 0; cyc < 2000 && !fin; cyc++) begin
            if (valid && !prev_valid) stall_left = stall;
            prev_valid = valid;
            if (stall_left > 0) begin
                ready = 1'b0;
                stall_left--;
                chk({tag, "_stall_valid"},  valid,  1);
                chk({tag, "_stall_prom_e"}, prom_e, 1);
                chk({tag, "_stall_sb"},     exp_d.size() == 0, 0);
                if (exp_d.size() != 0) chk({tag, "_stall_dout"}, dout, exp_d[0]);
            end else begin
                ready = 1'b1;
            end
            if (!prom_e) lowrun++;
            else if (lowrun > 0) begin
                chk({tag, "_access_len"}, lowrun, WC + 1);
                lowrun = 0;
            end
            if (done) begin
                fin = 1'b1;
            end else begin
                if (valid && ready) begin
                    chk({tag, "_sb_empty"}, exp_a.size() == 0, 0);
                    if (exp_a.size() != 0) begin
                        chk({tag, "_dout_a"}, dout_a, exp_a.pop_front());
                        chk({tag, "_dout"},   dout,   exp_d.pop_front());
                    end
                end
                step();
            end
        end
        start = 1'b0;
        chk({tag, "_done_seen"}, fin, 1);
        chk({tag, "_sb_left"}, exp_a.size(), 0);
`ifdef PROM_READER_CHECKSUM_EN
        chk({tag, "_csum"}, checksum, exp_csum);
`endif
        for (int k = 0; k < 3; k++) begin
            step();
            chk({tag, "_done_single"}, done, 0);
            chk({tag, "_busy_idle"},   busy, 0);
        end
        exp_a.delete();
        exp_d.delete();
    endtask

    initial begin : main
        int  hs;
        bit  found;

        rst = 1'b1; start = 1'b0; start_a = '0; count = '0; ready = 1'b1;
        repeat (3) step();
        chk_reset_vals("reset");
        rst = 1'b0;
        step();

        // Single word at 0x03 with exact cycle timing.
        start = 1'b1; start_a = 5'h03; count = 6'd1;
        step();
        start = 1'b0;
        chk("w1_busy_n",    busy,   1);
        chk("w1_prom_e_n",  prom_e, 0);
        chk("w1_prom_a_n",  prom_a, 5'h03);
        step();
        chk("w1_prom_e_n1", prom_e, 0);
        chk("w1_valid_n1",  valid,  0);
        step();
        chk("w1_prom_e_n2", prom_e, 0);
        chk("w1_valid_n2",  valid,  0);
        step();
        chk("w1_valid_n3",  valid,  1);
        chk("w1_prom_e_n3", prom_e, 1);
        chk("w1_dout",      dout,   8'hA6);
        chk("w1_dout_a",    dout_a, 5'h03);
        step();
        chk("w1_valid_n4",  valid,  0);
        chk("w1_done_n4",   done,   1);
        chk("w1_busy_n4",   busy,   1);
        step();
        chk("w1_done_n5",   done,   0);
        chk("w1_busy_n5",   busy,   0);
        chk("w1_prom_a_hold", prom_a, 5'h03);

        do_xfer("wrap",  5'h1E, 6'd4, 0, 1'b0);
        do_xfer("stall", 5'h10, 6'd2, 5, 1'b0);

        // Empty transfer.
        start = 1'b1; start_a = 5'h09; count = 6'd0;
        step();
        start = 1'b0;
        chk("cnt0_done",   done,   1);
        chk("cnt0_busy",   busy,   1);
        chk("cnt0_valid",  valid,  0);
        chk("cnt0_prom_e", prom_e, 1);
        step();
        chk("cnt0_done_end",  done,   0);
        chk("cnt0_busy_end",  busy,   0);
        chk("cnt0_valid_end", valid,  0);
        chk("cnt0_prom_e_end", prom_e, 1);

        do_xfer("noise", 5'h05, 6'd2, 0, 1'b1);

        // Reset during the third word's access of an 8-word transfer.
        start = 1'b1; start_a = 5'h00; count = 6'd8; ready = 1'b1;
        step();
        start = 1'b0;
        hs = 0;
        found = 1'b0;
        for (int cyc = 0; cyc < 200 && !found; cyc++) begin
            if (hs == 2 && !prom_e) begin
                found = 1'b1;
            end else begin
                if (valid && ready) begin
                    chk("rst_run_dout_a", dout_a, AW'(hs));
                    hs++;
                end
                step();
            end
        end
        chk("rst_reach_word3", found, 1);
        chk("rst_word3_addr",  prom_a, 5'h02);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_reset_vals("midrst");
        for (int k = 0; k < 4; k++) begin
            step();
            chk("midrst_no_done", done, 0);
        end

        do_xfer("after_rst", 5'h07, 6'd3, 0, 1'b0);

`ifdef PROM_READER_CHECKSUM_EN
        do_xfer("csum32", 5'h00, 6'd32, 0, 1'b0);
        chk("csum32_final", checksum, 8'hF0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
